nonce_arbiter: RTL and testbench
================================

Name: nonce_arbiter

Overview:
- Collects golden nonces from all hub slaves, both local miners and external-port receivers.
- Holds one pending nonce per slave and shares the single serial transmitter between them using round-robin arbitration, through a small output FIFO.
- Sequences the serial_transmit send/busy handshake.
- Counts nonces lost to overrun.
- Sits between the slaves' nonce_out/new_nonce outputs and the hub's serial transmitter.

Parameters:
SLAVES, 11, number of nonce sources (local miners + external ports)
FIFO_LOG2, 2, log2 of output FIFO depth (depth 4)
BUSY_TIMEOUT, 15, cycles to wait for serial_busy to rise after a send pulse

Ports:
hash_clk  in  1  single clock, all logic rising-edge
reset  in  1  synchronous, active-high
new_nonces  in  SLAVES  bit i = one-cycle strobe, slave i has a valid nonce
slave_nonces  in  SLAVES*32  nonce of slave i at bits [i*32+31:i*32], valid while strobe is high
serial_busy  in  1  transmitter busy
golden_nonce  out  32  word presented to the transmitter
serial_send  out  1  one-cycle send pulse
pending  out  SLAVES  per-slave slot-occupied flags
fifo_level  out  FIFO_LOG2+1  output FIFO occupancy, 0..2^FIFO_LOG2
drop_count  out  16  saturating count of lost nonces

Behaviour:
Reset:
- Synchronous; all outputs clear on the edge where reset=1: golden_nonce=0, serial_send=0, pending=0, fifo_level=0, drop_count=0.
- Round-robin pointer returns to 0; FSM returns to IDLE.
- Reset mid-transmission abandons all slots and FIFO contents without counting them as drops.
- After reset, the first send waits for serial_busy=0.

Capture:
- Each cycle, for each i with new_nonces[i]=1: if pending[i]=0, or slot i is granted this same cycle, latch the nonce into slot i and set pending[i] on the next edge.
- Otherwise the new nonce is discarded and drop_count increments.
- Multiple drops in one cycle add their total count.
- drop_count saturates at 0xFFFF.

Arbiter:
- Active each cycle when any pending bit is set and the FIFO is not full.
- Grants the first i with pending[i]=1, searching rr_ptr, rr_ptr+1, … and wrapping modulo SLAVES.
- On grant: the slot is written into the FIFO, pending[i] clears (unless re-set by a same-cycle strobe carrying the new value), and rr_ptr becomes (i+1) mod SLAVES.
- At most one grant per cycle.
- FIFO full: no grant, pending bits hold.
- FIFO push and pop in the same cycle: fifo_level is unchanged.

Transmit FSM (states IDLE, WAIT_BUSY, WAIT_DONE):
- IDLE: if fifo_level>0 and serial_busy=0, then golden_nonce<=FIFO head, pop, serial_send<=1 for exactly one cycle, go to WAIT_BUSY.
- WAIT_BUSY: serial_send=0.
  - If serial_busy=1, go to WAIT_DONE.
  - If BUSY_TIMEOUT cycles elapse without busy, increment drop_count and go to IDLE.
- WAIT_DONE: when serial_busy=0, go to IDLE.
- golden_nonce stays stable from the send pulse until the next send.
- Sends are never back-to-back; consecutive sends are at least 3 cycles apart.

Latency (empty FIFO, FSM idle, serial_busy=0):
- Strobe sampled at edge N.
- pending high after N.
- FIFO write at edge N+1.
- serial_send high after edge N+2, with golden_nonce valid in the same cycle.

Test Plan:
- Single nonce: slave 3 strobes 0xDEADBEEF; bench models busy rising the cycle after send, held 20 cycles → serial_send one cycle, 3 edges after the strobe; golden_nonce=0xDEADBEEF; drop_count=0.
- Simultaneous: slaves 0, 5, 9 strobe together with rr_ptr=0 → sent in order 0, 5, 9. Then slaves 2 and 7 strobe with rr_ptr=6 → order 7, 2.
- Overrun: busy held high; 5 slaves strobe once (4 to FIFO, 1 pending); that pending slave strobes again → drop_count=1, original value kept. Release busy → all 5 values sent in grant order.
- FIFO full backpressure: busy held high, slaves 0–5 strobe → fifo_level=4, pending=0b110000. Release busy → 6 sends, no drops.
- Busy timeout: serial_busy tied 0 → after the send, FSM returns to IDLE after 15 cycles; drop_count=1; next FIFO entry sent.
- Reset mid-operation: assert reset during WAIT_DONE with 2 FIFO entries and 1 pending → next cycle all outputs 0. After deassert, no send until a new strobe; drop_count stays 0.

Source files
------------

// File: rtl/nonce_arbiter.sv
// rtl/nonce_arbiter.sv - per-slave nonce slots, round-robin grant into a small FIFO,
// and the send/busy handshake towards the serial transmitter.
module nonce_arbiter #(
   parameter int SLAVES       = 11,
   parameter int FIFO_LOG2    = 2,
   parameter int BUSY_TIMEOUT = 15
) (
   input  logic                   hash_clk,
   input  logic                   reset,
   input  logic [SLAVES-1:0]      new_nonces,
   input  logic [SLAVES*32-1:0]   slave_nonces,
   input  logic                   serial_busy,
   output logic [31:0]            golden_nonce,
   output logic                   serial_send,
   output logic [SLAVES-1:0]      pending,
   output logic [FIFO_LOG2:0]     fifo_level,
   output logic [15:0]            drop_count
);

   localparam int DEPTH = 1 << FIFO_LOG2;
   localparam int PTR_W = (SLAVES > 1) ? $clog2(SLAVES) : 1;
   localparam int TMR_W = $clog2(BUSY_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

   state_t                 state_q;
   logic [31:0]            golden_q;
   logic                   send_q;
   logic [TMR_W-1:0]       timer_q;
   logic [31:0]            slot_q [SLAVES];
   logic [SLAVES-1:0]      pending_q, pending_d;
   logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [31:0]            fifo_mem_q [DEPTH];
   logic [FIFO_LOG2-1:0]   wr_ptr_q, rd_ptr_q;
   logic [FIFO_LOG2:0]     level_q, level_d;
   logic [15:0]            drop_q, drop_d;

   logic                   fifo_full, fifo_pop, timeout_drop;
   logic                   grant_valid;
   logic [PTR_W-1:0]       grant_idx, cand;
   logic [SLAVES-1:0]      slot_we;
   logic [4:0]             drops;
   logic [16:0]            drop_sum;
   int                     idx;

   assign fifo_full    = (level_q == (FIFO_LOG2+1)'(DEPTH));
   assign fifo_pop     = (state_q == IDLE) && (level_q != '0) && !serial_busy;
   assign timeout_drop = (state_q == WAIT_BUSY) && !serial_busy &&
                         (timer_q == TMR_W'(BUSY_TIMEOUT - 1));

   // Round-robin search starting at rr_ptr_q, wrapping modulo SLAVES.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      idx         = 0;
      cand        = '0;
      for (int k = 0; k < SLAVES; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= SLAVES) idx = idx - SLAVES;
         cand = PTR_W'(idx);
         if (!grant_valid && !fifo_full && pending_q[cand]) begin
            grant_valid = 1'b1;
            grant_idx   = cand;
         end
      end
      rr_ptr_d = (grant_idx == PTR_W'(SLAVES - 1)) ? '0 : grant_idx + PTR_W'(1);
   end

   // A strobe into a slot being granted this cycle refills it instead of dropping.
   always_comb begin
      pending_d = pending_q;
      slot_we   = '0;
      drops     = '0;
      for (int i = 0; i < SLAVES; i++) begin
         if (new_nonces[i] && (!pending_q[i] || (grant_valid && grant_idx == PTR_W'(i)))) begin
            slot_we[i]   = 1'b1;
            pending_d[i] = 1'b1;
         end else begin
            if (grant_valid && grant_idx == PTR_W'(i)) pending_d[i] = 1'b0;
            if (new_nonces[i]) drops = drops + 5'd1;
         end
      end
      drops    = drops + {4'b0, timeout_drop};
      drop_sum = {1'b0, drop_q} + {12'b0, drops};
      drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      level_d  = level_q;
      if (grant_valid && !fifo_pop)      level_d = level_q + (FIFO_LOG2+1)'(1);
      else if (!grant_valid && fifo_pop) level_d = level_q - (FIFO_LOG2+1)'(1);
   end

   always_ff @(posedge hash_clk) begin
      for (int i = 0; i < SLAVES; i++)
         if (slot_we[i]) slot_q[i] <= slave_nonces[i*32 +: 32];
      if (grant_valid) fifo_mem_q[wr_ptr_q] <= slot_q[grant_idx];
      if (reset) begin
         pending_q <= '0;
         rr_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         drop_q    <= '0;
      end else begin
         pending_q <= pending_d;
         level_q   <= level_d;
         drop_q    <= drop_d;
         if (grant_valid) begin
            rr_ptr_q <= rr_ptr_d;
            wr_ptr_q <= wr_ptr_q + FIFO_LOG2'(1);
         end
         if (fifo_pop) rd_ptr_q <= rd_ptr_q + FIFO_LOG2'(1);
      end
   end

   always_ff @(posedge hash_clk) begin
      if (reset) begin
         state_q  <= IDLE;
         golden_q <= '0;
         send_q   <= 1'b0;
         timer_q  <= '0;
      end else begin
         send_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (fifo_pop) begin
                  golden_q <= fifo_mem_q[rd_ptr_q];
                  send_q   <= 1'b1;
                  timer_q  <= '0;
                  state_q  <= WAIT_BUSY;
               end
            end
            WAIT_BUSY: begin
               if (serial_busy)  state_q <= WAIT_DONE;
               else if (timeout_drop) state_q <= IDLE;
               else timer_q <= timer_q + TMR_W'(1);
            end
            WAIT_DONE: begin
               if (!serial_busy) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign golden_nonce = golden_q;
   assign serial_send  = send_q;
   assign pending      = pending_q;
   assign fifo_level   = level_q;
   assign drop_count   = drop_q;

endmodule

// File: tb/tb_nonce_arbiter.sv
// tb/tb_nonce_arbiter.sv - directed bench for nonce_arbiter with a simple transmitter busy model.
module tb_nonce_arbiter;

   localparam int SLAVES = 11;

   logic                   hash_clk = 1'b0;
   logic                   reset = 1'b1;
   logic [SLAVES-1:0]      new_nonces = '0;
   logic [SLAVES*32-1:0]   slave_nonces = '0;
   logic                   serial_busy = 1'b0;
   logic [31:0]            golden_nonce;
   logic                   serial_send;
   logic [SLAVES-1:0]      pending;
   logic [2:0]             fifo_level;
   logic [15:0]            drop_count;

   int n_tests = 0;
   int n_fail = 0;
   int cyc = 0;
   int last_send = -100;
   int busy_mode = 0;   // 0: driven by test, 1: held high, 2: rises after send for 20 cycles
   int busy_cnt = 0;
   logic [31:0] sent_q [$];

   nonce_arbiter #(.SLAVES(11), .FIFO_LOG2(2), .BUSY_TIMEOUT(15)) dut (
      .hash_clk     (hash_clk),
      .reset        (reset),
      .new_nonces   (new_nonces),
      .slave_nonces (slave_nonces),
      .serial_busy  (serial_busy),
      .golden_nonce (golden_nonce),
      .serial_send  (serial_send),
      .pending      (pending),
      .fifo_level   (fifo_level),
      .drop_count   (drop_count)
   );

   always #5 hash_clk = ~hash_clk;

   function automatic logic [31:0] nv(input logic [15:0] tag, input int i);
      return {tag, 16'(i)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge hash_clk);
      #1;
      cyc++;
      if (serial_send === 1'b1) begin
         sent_q.push_back(golden_nonce);
         chk("send_spacing", 32'(cyc - last_send >= 3), 32'd1);
         last_send = cyc;
         if (busy_mode == 2) begin
            serial_busy = 1'b1;
            busy_cnt = 20;
         end
      end else if (busy_mode == 2 && busy_cnt > 0) begin
         busy_cnt--;
         if (busy_cnt == 0) serial_busy = 1'b0;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      new_nonces = '0;
      serial_busy = 1'b0;
      busy_cnt = 0;
      busy_mode = 0;
      tick();
      tick();
      reset = 1'b0;
      sent_q.delete();
      last_send = -100;
   endtask

   task automatic strobe(input logic [SLAVES-1:0] mask, input logic [15:0] tag);
      for (int i = 0; i < SLAVES; i++)
         if (mask[i]) slave_nonces[i*32 +: 32] = nv(tag, i);
      new_nonces = mask;
      tick();
      new_nonces = '0;
   endtask

   task automatic wait_sends(input int n, input int budget, input string tag);
      int k = 0;
      while (sent_q.size() < n && k < budget) begin
         tick();
         k++;
      end
      chk(tag, 32'(sent_q.size()), 32'(n));
   endtask

   task automatic chk_sent(input int j, input logic [31:0] exp, input string tag);
      logic [31:0] v;
      v = (j < sent_q.size()) ? sent_q[j] : 32'hxxxxxxxx;
      chk(tag, v, exp);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_golden"}, golden_nonce, 32'h0);
      chk({tag, "_send"}, 32'(serial_send), 32'h0);
      chk({tag, "_pending"}, 32'(pending), 32'h0);
      chk({tag, "_level"}, 32'(fifo_level), 32'h0);
      chk({tag, "_drop"}, 32'(drop_count), 32'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state and single nonce latency
      do_reset();
      chk_zero("reset");
      busy_mode = 2;
      slave_nonces[3*32 +: 32] = 32'hDEADBEEF;
      new_nonces = 11'(1 << 3);
      tick();
      new_nonces = '0;
      chk("t1_pending_n", 32'(pending), 32'h008);
      chk("t1_send_n", 32'(serial_send), 32'h0);
      tick();
      chk("t1_level_n1", 32'(fifo_level), 32'h1);
      chk("t1_pending_n1", 32'(pending), 32'h0);
      tick();
      chk("t1_send_n2", 32'(serial_send), 32'h1);
      chk("t1_golden_n2", golden_nonce, 32'hDEADBEEF);
      chk("t1_level_n2", 32'(fifo_level), 32'h0);
      tick();
      chk("t1_send_pulse_end", 32'(serial_send), 32'h0);
      chk("t1_golden_hold", golden_nonce, 32'hDEADBEEF);
      repeat (25) tick();
      chk("t1_drop", 32'(drop_count), 32'h0);
      chk("t1_nsent", 32'(sent_q.size()), 32'd1);

      // Simultaneous strobes from rr_ptr=0
      do_reset();
      busy_mode = 2;
      strobe(11'b010_0010_0001, 16'h2000);
      wait_sends(3, 200, "t2a_count");
      chk_sent(0, nv(16'h2000, 0), "t2a_first");
      chk_sent(1, nv(16'h2000, 5), "t2a_second");
      chk_sent(2, nv(16'h2000, 9), "t2a_third");

      // Wrap-around order from rr_ptr=6
      do_reset();
      busy_mode = 2;
      strobe(11'(1 << 5), 16'h2100);
      wait_sends(1, 50, "t2b_prime");
      sent_q.delete();
      strobe(11'((1 << 2) | (1 << 7)), 16'h2200);
      wait_sends(2, 200, "t2b_count");
      chk_sent(0, nv(16'h2200, 7), "t2b_first");
      chk_sent(1, nv(16'h2200, 2), "t2b_second");

      // Overrun of a pending slot
      do_reset();
      busy_mode = 1;
      serial_busy = 1'b1;
      strobe(11'b000_0101_1110, 16'h3000);
      repeat (6) tick();
      chk("t3_level_full", 32'(fifo_level), 32'h4);
      chk("t3_pending", 32'(pending), 32'h040);
      strobe(11'(1 << 6), 16'h3100);
      chk("t3_drop", 32'(drop_count), 32'h1);
      chk("t3_pending_hold", 32'(pending), 32'h040);
      busy_mode = 2;
      busy_cnt = 0;
      serial_busy = 1'b0;
      wait_sends(5, 300, "t3_count");
      chk_sent(0, nv(16'h3000, 1), "t3_s0");
      chk_sent(1, nv(16'h3000, 2), "t3_s1");
      chk_sent(2, nv(16'h3000, 3), "t3_s2");
      chk_sent(3, nv(16'h3000, 4), "t3_s3");
      chk_sent(4, nv(16'h3000, 6), "t3_s4_original");
      chk("t3_drop_final", 32'(drop_count), 32'h1);

      // FIFO-full backpressure
      do_reset();
      busy_mode = 1;
      serial_busy = 1'b1;
      strobe(11'b000_0011_1111, 16'h4000);
      repeat (6) tick();
      chk("t4_level", 32'(fifo_level), 32'h4);
      chk("t4_pending", 32'(pending), 32'h030);
      busy_mode = 2;
      busy_cnt = 0;
      serial_busy = 1'b0;
      wait_sends(6, 400, "t4_count");
      for (int j = 0; j < 6; j++) chk_sent(j, nv(16'h4000, j), "t4_order");
      chk("t4_drop", 32'(drop_count), 32'h0);

      // Busy never rises: timeout
      do_reset();
      busy_mode = 0;
      serial_busy = 1'b0;
      strobe(11'b000_0000_0110, 16'h5000);
      tick();
      tick();
      chk("t5_send", 32'(serial_send), 32'h1);
      chk("t5_golden", golden_nonce, nv(16'h5000, 1));
      chk("t5_level_pushpop", 32'(fifo_level), 32'h1);
      repeat (14) tick();
      chk("t5_drop_before", 32'(drop_count), 32'h0);
      chk("t5_no_send_yet", 32'(serial_send), 32'h0);
      tick();
      chk("t5_drop_timeout", 32'(drop_count), 32'h1);
      tick();
      chk("t5_next_send", 32'(serial_send), 32'h1);
      chk("t5_next_golden", golden_nonce, nv(16'h5000, 2));

      // Reset during WAIT_DONE
      do_reset();
      busy_mode = 2;
      strobe(11'b000_0000_1111, 16'h6000);
      tick();
      tick();
      tick();
      chk("t6_level", 32'(fifo_level), 32'h2);
      chk("t6_pending", 32'(pending), 32'h008);
      reset = 1'b1;
      tick();
      chk_zero("t6_reset");
      reset = 1'b0;
      serial_busy = 1'b0;
      busy_cnt = 0;
      sent_q.delete();
      repeat (20) tick();
      chk("t6_no_send", 32'(sent_q.size()), 32'h0);
      chk("t6_drop", 32'(drop_count), 32'h0);
      strobe(11'(1 << 8), 16'h6100);
      wait_sends(1, 20, "t6_count");
      chk_sent(0, nv(16'h6100, 8), "t6_value");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
